// File: rtl/multdiv_scheduler.sv
// Sequencer for the shared multi-cycle mult/div unit: start pulses, RAW/WAW tracking, regfile write-port arbitration.
// Optional MULTDIV_EXC_EN turns unit exceptions into an r30 status write carrying a mul/div code.
module multdiv_scheduler #(
  parameter int unsigned TIMEOUT = 40,
  parameter int unsigned REG_W   = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             x_mul,
  input  logic             x_div,
  input  logic [REG_W-1:0] x_rd,
  input  logic             d_is_muldiv,
  input  logic [REG_W-1:0] d_rs,
  input  logic [REG_W-1:0] d_rt,
  input  logic             unit_ready,
  input  logic             unit_exception,
  input  logic             mw_we,
  input  logic [REG_W-1:0] mw_rd,
  output logic             ctrl_start_mult,
  output logic             ctrl_start_div,
  output logic             busy,
  output logic             stall_front,
  output logic             pw_en,
  output logic             wb_sel_p,
  output logic             wb_we,
  output logic [REG_W-1:0] wb_rd,
  output logic [2:0]       wb_exc_code,
  output logic             timeout_err
);

  localparam int unsigned CNT_W = 6;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_BUSY  = 2'd2;
  localparam logic [1:0] S_WB    = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [REG_W-1:0] pending_rd_q, pending_rd_d;
  logic             kind_div_q, kind_div_d;
  logic             stale_q, stale_d;
  logic [CNT_W-1:0] count_q, count_d;

`ifdef MULTDIV_EXC_EN
  logic             exc_q, exc_d;
`else
  logic             exc_unused;
  assign exc_unused = unit_exception;
`endif

  // State advances on the falling edge, in step with the pipeline latches.
  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pending_rd_q <= '0;
      kind_div_q   <= 1'b0;
      stale_q      <= 1'b0;
      count_q      <= '0;
`ifdef MULTDIV_EXC_EN
      exc_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pending_rd_q <= pending_rd_d;
      kind_div_q   <= kind_div_d;
      stale_q      <= stale_d;
      count_q      <= count_d;
`ifdef MULTDIV_EXC_EN
      exc_q        <= exc_d;
`endif
    end
  end

  // Next state and outputs; everything is held at zero while reset is asserted.
  always_comb begin
    state_d         = state_q;
    pending_rd_d    = pending_rd_q;
    kind_div_d      = kind_div_q;
    stale_d         = stale_q;
    count_d         = count_q;
`ifdef MULTDIV_EXC_EN
    exc_d           = exc_q;
`endif
    ctrl_start_mult = 1'b0;
    ctrl_start_div  = 1'b0;
    busy            = 1'b0;
    stall_front     = 1'b0;
    pw_en           = 1'b0;
    wb_sel_p        = 1'b0;
    wb_we           = 1'b0;
    wb_rd           = '0;
    wb_exc_code     = 3'd0;
    timeout_err     = 1'b0;

    if (!reset) begin
      wb_we = mw_we;
      wb_rd = mw_rd;

      unique case (state_q)
        S_IDLE: begin
          if (x_mul || x_div) begin
            state_d      = S_START;
            pending_rd_d = x_rd;
            kind_div_d   = ~x_mul;
`ifdef MULTDIV_EXC_EN
            exc_d        = 1'b0;
`endif
          end
        end
        S_START: begin
          ctrl_start_mult = ~kind_div_q;
          ctrl_start_div  = kind_div_q;
          count_d         = '0;
          state_d         = S_BUSY;
        end
        S_BUSY: begin
          count_d = count_q + CNT_W'(1);
          if (unit_ready) begin
            pw_en   = 1'b1;
            state_d = S_WB;
`ifdef MULTDIV_EXC_EN
            exc_d   = unit_exception;
`endif
          end else if (count_q == CNT_W'(TIMEOUT - 1)) begin
            timeout_err = 1'b1;
            state_d     = S_IDLE;
          end
        end
        S_WB: begin
          // MW owns the port while it writes; hold the front end so only bubbles follow.
          if (mw_we) begin
            stall_front = 1'b1;
          end else begin
            wb_sel_p = 1'b1;
            wb_rd    = pending_rd_q;
            wb_we    = ~stale_q & (pending_rd_q != '0);
`ifdef MULTDIV_EXC_EN
            if (exc_q) begin
              wb_rd       = REG_W'(30);
              wb_we       = 1'b1;
              wb_exc_code = kind_div_q ? 3'd5 : 3'd4;
            end
`endif
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase

      busy = (state_q != S_IDLE);

      if (busy) begin
        if (mw_we && (mw_rd == pending_rd_q)) begin
          stale_d = 1'b1;
        end
        if (d_is_muldiv) begin
          stall_front = 1'b1;
        end
        if ((pending_rd_q != '0) && !stale_q &&
            ((d_rs == pending_rd_q) || (d_rt == pending_rd_q))) begin
          stall_front = 1'b1;
        end
      end

      if (state_d == S_IDLE) begin
        stale_d = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_multdiv_scheduler.sv
// Directed bench for multdiv_scheduler: cycle-by-cycle vector table plus hand sequences for latency, timeout and async reset.
module tb_multdiv_scheduler;

  logic       clock;
  logic       reset;
  logic       x_mul, x_div;
  logic [4:0] x_rd;
  logic       d_is_muldiv;
  logic [4:0] d_rs, d_rt;
  logic       unit_ready, unit_exception;
  logic       mw_we;
  logic [4:0] mw_rd;
  logic       ctrl_start_mult, ctrl_start_div, busy, stall_front, pw_en;
  logic       wb_sel_p, wb_we, timeout_err;
  logic [4:0] wb_rd;
  logic [2:0] wb_exc_code;

  int n_cmp = 0;
  int n_bad = 0;

  multdiv_scheduler #(.TIMEOUT(40), .REG_W(5)) dut (
    .clock(clock), .reset(reset),
    .x_mul(x_mul), .x_div(x_div), .x_rd(x_rd),
    .d_is_muldiv(d_is_muldiv), .d_rs(d_rs), .d_rt(d_rt),
    .unit_ready(unit_ready), .unit_exception(unit_exception),
    .mw_we(mw_we), .mw_rd(mw_rd),
    .ctrl_start_mult(ctrl_start_mult), .ctrl_start_div(ctrl_start_div),
    .busy(busy), .stall_front(stall_front), .pw_en(pw_en),
    .wb_sel_p(wb_sel_p), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_exc_code(wb_exc_code), .timeout_err(timeout_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       nm;
    logic        rst, xm, xd;
    logic [4:0]  xrd;
    logic        dmd;
    logic [4:0]  rs, rt;
    logic        rdy, exc, mwe;
    logic [4:0]  mrd;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];

  // Packed view: {start_mult, start_div, busy, stall, pw_en, sel_p, we, rd[4:0], code[2:0], timeout}
  function automatic logic [15:0] pk(logic sm, logic sd, logic bz, logic st, logic pw,
                                      logic sp, logic we, logic [4:0] rd, logic [2:0] code,
                                      logic te);
    return {sm, sd, bz, st, pw, sp, we, rd, code, te};
  endfunction

  function automatic logic [15:0] outs();
    return {ctrl_start_mult, ctrl_start_div, busy, stall_front, pw_en,
            wb_sel_p, wb_we, wb_rd, wb_exc_code, timeout_err};
  endfunction

  function void add(string nm, logic rst, logic xm, logic xd, logic [4:0] xrd, logic dmd,
                    logic [4:0] rs, logic [4:0] rt, logic rdy, logic exc, logic mwe,
                    logic [4:0] mrd, logic [15:0] exp);
    vec_t v;
    v.nm = nm; v.rst = rst; v.xm = xm; v.xd = xd; v.xrd = xrd; v.dmd = dmd;
    v.rs = rs; v.rt = rt; v.rdy = rdy; v.exc = exc; v.mwe = mwe; v.mrd = mrd; v.exp = exp;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic clr();
    x_mul = 0; x_div = 0; x_rd = 0; d_is_muldiv = 0; d_rs = 0; d_rt = 0;
    unit_ready = 0; unit_exception = 0; mw_we = 0; mw_rd = 0;
  endtask

  // Inputs change just after the falling (active) edge; outputs are sampled 1 time unit later.
  task automatic next_cycle();
    @(negedge clock);
    #1;
  endtask

  logic [15:0] exp_div_wb;
  logic [15:0] got;
  int          hit;
  int          bad_busy;

  initial begin
    reset = 1'b1;
    clr();

`ifdef MULTDIV_EXC_EN
    exp_div_wb = pk(0,0,1,0,0,1,1,5'd30,3'd5,0);
`else
    exp_div_wb = pk(0,0,1,0,0,1,1,5'd4,3'd0,0);
`endif

    //   name            rst xm xd xrd dmd rs rt rdy exc mwe mrd  expected
    add("reset_gated",    1, 0,0, 0,  0,  0, 0, 0,  0,  1,  3, pk(0,0,0,0,0,0,0,0,0,0));
    add("idle_mw_pass",   0, 0,0, 0,  0,  0, 0, 0,  0,  1,  3, pk(0,0,0,0,0,0,1,3,0,0));
    add("issue_mul5",     0, 1,0, 5,  0,  0, 0, 0,  0,  0,  0, pk(0,0,0,0,0,0,0,0,0,0));
    add("start_raw_rs",   0, 0,0, 0,  0,  5, 0, 0,  0,  0,  0, pk(1,0,1,1,0,0,0,0,0,0));
    add("busy_raw_rs",    0, 0,0, 0,  0,  5, 0, 0,  0,  0,  0, pk(0,0,1,1,0,0,0,0,0,0));
    add("busy_no_raw",    0, 0,0, 0,  0,  6, 7, 0,  0,  0,  0, pk(0,0,1,0,0,0,0,0,0,0));
    add("busy_raw_rt",    0, 0,0, 0,  0,  6, 5, 0,  0,  0,  0, pk(0,0,1,1,0,0,0,0,0,0));
    add("busy_b2b_md",    0, 0,0, 0,  1,  0, 0, 0,  0,  0,  0, pk(0,0,1,1,0,0,0,0,0,0));
    add("busy_ready",     0, 0,0, 0,  0,  0, 0, 1,  0,  0,  0, pk(0,0,1,0,1,0,0,0,0,0));
    add("wb_mw_wins1",    0, 0,0, 0,  0,  0, 0, 0,  0,  1,  9, pk(0,0,1,1,0,0,1,9,0,0));
    add("wb_mw_wins2",    0, 0,0, 0,  0,  0, 0, 0,  0,  1,  9, pk(0,0,1,1,0,0,1,9,0,0));
    add("wb_p_write5",    0, 0,0, 0,  0,  0, 0, 0,  0,  0,  0, pk(0,0,1,0,0,1,1,5,0,0));
    add("idle_after5",    0, 0,0, 0,  0,  0, 0, 0,  0,  0,  0, pk(0,0,0,0,0,0,0,0,0,0));
    add("issue_mul8",     0, 1,0, 8,  0,  0, 0, 0,  0,  0,  0, pk(0,0,0,0,0,0,0,0,0,0));
    add("start_waw8",     0, 0,0, 0,  0,  0, 0, 0,  0,  1,  8, pk(1,0,1,0,0,0,1,8,0,0));
    add("busy_stale_rs",  0, 0,0, 0,  0,  8, 0, 0,  0,  0,  0, pk(0,0,1,0,0,0,0,0,0,0));
    add("busy_ready8",    0, 0,0, 0,  0,  0, 0, 1,  0,  0,  0, pk(0,0,1,0,1,0,0,0,0,0));
    add("wb_stale_supp",  0, 0,0, 0,  0,  0, 0, 0,  0,  0,  0, pk(0,0,1,0,0,1,0,8,0,0));
    add("idle_after8",    0, 0,0, 0,  0,  0, 0, 0,  0,  0,  0, pk(0,0,0,0,0,0,0,0,0,0));
    add("issue_div4",     0, 0,1, 4,  0,  0, 0, 0,  0,  0,  0, pk(0,0,0,0,0,0,0,0,0,0));
    add("start_div_rs",   0, 0,0, 0,  0,  4, 0, 0,  0,  0,  0, pk(0,1,1,1,0,0,0,0,0,0));
    add("busy_rdy_exc",   0, 0,0, 0,  0,  0, 0, 1,  1,  0,  0, pk(0,0,1,0,1,0,0,0,0,0));
    add("wb_div_exc",     0, 0,0, 0,  0,  0, 0, 0,  0,  0,  0, exp_div_wb);
    add("idle_after4",    0, 0,0, 0,  0,  0, 0, 0,  0,  0,  0, pk(0,0,0,0,0,0,0,0,0,0));
    add("issue_both_rd0", 0, 1,1, 0,  0,  0, 0, 0,  0,  0,  0, pk(0,0,0,0,0,0,0,0,0,0));
    add("start_mul_wins", 0, 0,0, 0,  0,  0, 0, 0,  0,  0,  0, pk(1,0,1,0,0,0,0,0,0,0));
    add("busy_rd0_nosrc", 0, 0,0, 0,  0,  0, 0, 1,  0,  0,  0, pk(0,0,1,0,1,0,0,0,0,0));
    add("wb_rd0_nowrite", 0, 0,0, 0,  0,  0, 0, 0,  0,  0,  0, pk(0,0,1,0,0,1,0,0,0,0));
    add("idle_after0",    0, 0,0, 0,  0,  0, 0, 0,  0,  0,  0, pk(0,0,0,0,0,0,0,0,0,0));

    foreach (vecs[i]) begin
      next_cycle();
      reset = vecs[i].rst; x_mul = vecs[i].xm; x_div = vecs[i].xd; x_rd = vecs[i].xrd;
      d_is_muldiv = vecs[i].dmd; d_rs = vecs[i].rs; d_rt = vecs[i].rt;
      unit_ready = vecs[i].rdy; unit_exception = vecs[i].exc;
      mw_we = vecs[i].mwe; mw_rd = vecs[i].mrd;
      #1;
      chk(vecs[i].nm, outs(), vecs[i].exp);
    end

    // Long unit latency: single start pulse, ready after 32 cycles, P write next cycle.
    next_cycle(); clr(); x_mul = 1; x_rd = 5; #1;
    chk("lat_issue", outs(), pk(0,0,0,0,0,0,0,0,0,0));
    next_cycle(); clr(); #1;
    chk("lat_start_pulse", outs(), pk(1,0,1,0,0,0,0,0,0,0));
    bad_busy = 0;
    for (int i = 0; i < 31; i++) begin
      next_cycle(); #1;
      if (outs() !== pk(0,0,1,0,0,0,0,0,0,0)) bad_busy++;
    end
    chk_int("lat_busy_quiet", bad_busy, 0);
    next_cycle(); unit_ready = 1; #1;
    chk("lat_ready", outs(), pk(0,0,1,0,1,0,0,0,0,0));
    next_cycle(); unit_ready = 0; #1;
    chk("lat_wb5", outs(), pk(0,0,1,0,0,1,1,5,0,0));
    next_cycle(); #1;
    chk("lat_idle", outs(), pk(0,0,0,0,0,0,0,0,0,0));

    // Timeout: no unit_ready; abort pulse on the 40th BUSY cycle, no P write afterwards.
    next_cycle(); clr(); x_mul = 1; x_rd = 6; #1;
    next_cycle(); clr(); #1;
    chk("to_start", outs(), pk(1,0,1,0,0,0,0,0,0,0));
    hit = -1;
    got = '0;
    for (int i = 0; i < 60; i++) begin
      next_cycle(); #1;
      if (timeout_err === 1'b1) begin
        hit = i;
        got = outs();
        break;
      end
    end
    chk_int("to_cycle", hit, 39);
    chk("to_pulse", got, pk(0,0,1,0,0,0,0,0,0,1));
    next_cycle(); #1;
    chk("to_after1", outs(), pk(0,0,0,0,0,0,0,0,0,0));
    next_cycle(); #1;
    chk("to_after2", outs(), pk(0,0,0,0,0,0,0,0,0,0));

    // Async reset mid-BUSY clears outputs without waiting for a clock edge.
    next_cycle(); clr(); x_mul = 1; x_rd = 7; #1;
    next_cycle(); clr(); #1;
    next_cycle(); #1;
    next_cycle(); mw_we = 1; mw_rd = 3; d_rs = 7; #1;
    chk("rst_pre", outs(), pk(0,0,1,1,0,0,1,3,0,0));
    #1 reset = 1'b1;
    #1;
    chk("rst_async", outs(), pk(0,0,0,0,0,0,0,0,0,0));
    next_cycle(); reset = 1'b0; clr(); unit_ready = 1; #1;
    chk("rst_abandon1", outs(), pk(0,0,0,0,0,0,0,0,0,0));
    next_cycle(); #1;
    chk("rst_abandon2", outs(), pk(0,0,0,0,0,0,0,0,0,0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multdiv_scheduler.md
Name: multdiv_scheduler

Overview:
Sequences the shared multi-cycle mult/div unit for the 5-stage pipeline. Issues start pulses and tracks the pending destination register. Stalls the front end on RAW hazards and back-to-back mult/div. Arbitrates the single regfile write port between the P/W path and the M/W path.

Parameters:
TIMEOUT, 40, max cycles BUSY may wait for unit_ready before abort (6-bit counter, max 63)
REG_W, 5, register index width

Ports:
clock  in  1  system clock; state updates on falling edge, matching the pipeline latches
reset  in  1  asynchronous, active-high; clears all state
x_mul  in  1  DX-stage instruction is mul
x_div  in  1  DX-stage instruction is div
x_rd  in  REG_W  DX-stage destination
d_is_muldiv  in  1  FD-stage instruction is mul or div
d_rs  in  REG_W  FD-stage source A
d_rt  in  REG_W  FD-stage source B
unit_ready  in  1  unit result valid (level)
unit_exception  in  1  unit overflow/div-by-zero, valid with unit_ready
mw_we  in  1  MW stage requests regfile write
mw_rd  in  REG_W  MW-stage destination
ctrl_start_mult  out  1  one-cycle start pulse to unit
ctrl_start_div  out  1  one-cycle start pulse to unit
busy  out  1  state != IDLE
stall_front  out  1  hold PC and FD; insert nop into DX
pw_en  out  1  P/W latch capture enable
wb_sel_p  out  1  regfile write data from P (else from MW)
wb_we  out  1  regfile write enable this cycle
wb_rd  out  REG_W  regfile write index
wb_exc_code  out  3  status code for r30 write; 0 = none
timeout_err  out  1  one-cycle pulse on abort

Behaviour:
- Reset: state IDLE; pending_rd = 0, stale = 0, count = 0; all outputs 0. Reset mid-operation abandons the op; no writeback.
- IDLE:
  - x_mul or x_div → START. Latch pending_rd = x_rd and kind.
  - Both asserted: mul wins.
- START (1 cycle): assert the start pulse for kind; count = 0 → BUSY.
- BUSY:
  - count increments each cycle.
  - unit_ready → WB; pw_en = 1 that cycle.
  - count == TIMEOUT-1 without ready → IDLE; timeout_err = 1; no writeback.
- WB:
  - mw_we = 0: wb_we = ~stale & (pending_rd != 0); wb_sel_p = 1; wb_rd = pending_rd → IDLE.
  - mw_we = 1: MW wins; wb_sel_p = 0; wb_we/wb_rd follow mw_we/mw_rd. Stay in WB with stall_front = 1 until mw_we drops, so the pipeline drains bubbles.
- Outside WB: wb_we = mw_we; wb_rd = mw_rd; wb_sel_p = 0.
- Hazards while busy (START, BUSY, WB), with pending_rd != 0 and stale = 0:
  - stall_front = 1 if d_rs == pending_rd or d_rt == pending_rd.
  - stall_front = 1 if d_is_muldiv, regardless of pending_rd.
- Write-after-write: in START/BUSY/WB, mw_we & (mw_rd == pending_rd) sets stale = 1. The younger result wins; the P write is suppressed. stale clears on IDLE entry.
- x_mul/x_div while not IDLE cannot occur (prevented by stall); ignored.
- Latency: start pulse 1 cycle after DX issue. Writeback no earlier than 1 cycle after unit_ready.

Optional Feature:
MULTDIV_EXC_EN:
- Defined: unit_exception with unit_ready latches exc. In WB (when granted), wb_rd = 30 and wb_exc_code = 4 (mul) / 5 (div); write is not suppressed by stale.
- Undefined: unit_exception ignored; wb_exc_code tied 0.

Test Plan:
- Reset, then x_mul=1, x_rd=5 → ctrl_start_mult=1 for exactly 1 cycle, 1 cycle later. unit_ready after 32 cycles → next cycle wb_we=1, wb_sel_p=1, wb_rd=5, then busy=0.
- During BUSY for rd=5, d_rs=5 → stall_front=1 until WB. d_rs=6, d_rt=7 → stall_front=0. pending_rd=0 → never stalls on sources.
- WB coincides with mw_we=1, mw_rd=9 for 2 cycles → wb_rd=9, wb_sel_p=0 both cycles with stall_front=1; third cycle wb_rd=5, wb_sel_p=1.
- BUSY for rd=8; MW writes rd=8 → stale set; at WB, wb_we=0; next op starts with stale cleared.
- No unit_ready for TIMEOUT=40 cycles → timeout_err pulses once; busy=0; no P write. Reset asserted mid-BUSY → all outputs 0 immediately (async).
- With MULTDIV_EXC_EN, div with unit_exception=1 → WB gives wb_rd=30, wb_exc_code=5. Without the macro → wb_rd=pending_rd, wb_exc_code=0.
